// File: rtl/ultra_scan_ctrl.sv
// Round-robin ultrasonic ranging scheduler: one trigger at a time, one shared echo-width
// timer, a quiet holdoff between shots, and one registered result strobe per shot.
module ultra_scan_ctrl #(
    parameter int N_SENS    = 4,
    parameter int CNT_W     = 17,
    parameter int TRIG_CYC  = 1000,
    parameter int ECHO_WAIT = 50000,
    parameter int MAX_W     = 131071,
    parameter int HOLD_CYC  = 6000
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              run,
    input  logic              start,
    input  logic [N_SENS-1:0] echo,
    output logic [N_SENS-1:0] trig,
    output logic              busy,
    output logic              res_valid,
    output logic [2:0]        res_id,
    output logic [CNT_W-1:0]  res_width,
    output logic              res_timeout
);

    localparam int SEL_W = (N_SENS > 1) ? $clog2(N_SENS) : 1;

    localparam logic [CNT_W-1:0] L_TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] L_WAIT_LAST = CNT_W'(ECHO_WAIT - 1);
    localparam logic [CNT_W-1:0] L_MAXW_LAST = CNT_W'(MAX_W - 1);
    localparam logic [CNT_W-1:0] L_MAXW      = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] L_HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] L_CNT_ONE   = CNT_W'(1);
    localparam logic [SEL_W-1:0] L_SEL_LAST  = SEL_W'(N_SENS - 1);
    localparam logic [SEL_W-1:0] L_SEL_ONE   = SEL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sweep;
    logic [N_SENS-1:0]  r_sync1;
    logic [N_SENS-1:0]  r_sync2;
    logic               r_echo_prev;
    logic [N_SENS-1:0]  r_trig;
    logic               r_busy;
    logic               r_res_valid;
    logic [2:0]         r_res_id;
    logic [CNT_W-1:0]   r_res_width;
    logic               r_res_timeout;

    logic               w_echo_sel;
    logic               w_rise;
    logic               w_wrap;
    logic [SEL_W-1:0]   w_sel_nxt;

    function automatic logic [N_SENS-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        logic [N_SENS-1:0] v;
        v    = {N_SENS{1'b0}};
        v[s] = 1'b1;
        return v;
    endfunction

    // Two-flop synchroniser per echo line plus the previous synced level of the selected line.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= {N_SENS{1'b0}};
            r_sync2     <= {N_SENS{1'b0}};
            r_echo_prev <= 1'b0;
        end else begin
            r_sync1     <= echo;
            r_sync2     <= r_sync1;
            r_echo_prev <= w_echo_sel;
        end
    end

    // Selected echo level, its rising edge, and the next sensor index.
    always_comb begin
        w_echo_sel = r_sync2[r_sel];
        w_rise     = w_echo_sel & ~r_echo_prev;
        w_wrap     = (r_sel == L_SEL_LAST);
        if (w_wrap) begin
            w_sel_nxt = {SEL_W{1'b0}};
        end else begin
            w_sel_nxt = r_sel + L_SEL_ONE;
        end
    end

    // Scan FSM with registered trigger, busy and result outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_sel         <= {SEL_W{1'b0}};
            r_cnt         <= {CNT_W{1'b0}};
            r_sweep       <= 1'b0;
            r_trig        <= {N_SENS{1'b0}};
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_id      <= 3'd0;
            r_res_width   <= {CNT_W{1'b0}};
            r_res_timeout <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sel <= {SEL_W{1'b0}};
                    r_cnt <= {CNT_W{1'b0}};
                    // start together with run behaves as plain run, so no sweep is armed
                    if (run || start) begin
                        r_state <= S_TRIG;
                        r_busy  <= 1'b1;
                        r_sweep <= ~run;
                        r_trig  <= sel_onehot({SEL_W{1'b0}});
                    end
                end
                S_TRIG: begin
                    if (r_cnt == L_TRIG_LAST) begin
                        r_trig  <= {N_SENS{1'b0}};
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= S_WAIT_RISE;
                    end else begin
                        r_cnt <= r_cnt + L_CNT_ONE;
                    end
                end
                S_WAIT_RISE: begin
                    if (w_rise) begin
                        r_cnt   <= L_CNT_ONE;
                        r_state <= S_MEASURE;
                    end else if (r_cnt == L_WAIT_LAST) begin
                        r_res_valid   <= 1'b1;
                        r_res_id      <= 3'(r_sel);
                        r_res_width   <= {CNT_W{1'b0}};
                        r_res_timeout <= 1'b1;
                        r_cnt         <= {CNT_W{1'b0}};
                        r_state       <= S_HOLDOFF;
                    end else begin
                        r_cnt <= r_cnt + L_CNT_ONE;
                    end
                end
                S_MEASURE: begin
                    if (!w_echo_sel) begin
                        r_res_valid   <= 1'b1;
                        r_res_id      <= 3'(r_sel);
                        r_res_width   <= r_cnt;
                        r_res_timeout <= 1'b0;
                        r_cnt         <= {CNT_W{1'b0}};
                        r_state       <= S_HOLDOFF;
                    end else if (r_cnt == L_MAXW_LAST) begin
                        // this high cycle would bring the count to MAX_W
                        r_res_valid   <= 1'b1;
                        r_res_id      <= 3'(r_sel);
                        r_res_width   <= L_MAXW;
                        r_res_timeout <= 1'b1;
                        r_cnt         <= {CNT_W{1'b0}};
                        r_state       <= S_HOLDOFF;
                    end else begin
                        r_cnt <= r_cnt + L_CNT_ONE;
                    end
                end
                S_HOLDOFF: begin
                    if (r_cnt == L_HOLD_LAST) begin
                        r_cnt <= {CNT_W{1'b0}};
                        if (run || (r_sweep && !w_wrap)) begin
                            r_sel   <= w_sel_nxt;
                            r_trig  <= sel_onehot(w_sel_nxt);
                            r_state <= S_TRIG;
                        end else begin
                            r_sel   <= {SEL_W{1'b0}};
                            r_sweep <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + L_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sel   <= {SEL_W{1'b0}};
                    r_cnt   <= {CNT_W{1'b0}};
                    r_sweep <= 1'b0;
                    r_trig  <= {N_SENS{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign trig        = r_trig;
    assign busy        = r_busy;
    assign res_valid   = r_res_valid;
    assign res_id      = r_res_id;
    assign res_width   = r_res_width;
    assign res_timeout = r_res_timeout;

endmodule
